snn_layer_par: RTL

SNN_LAYER_PAR -- requirements
Module: snn_layer_par

---
 rtl/snn_layer_par.sv | 114 +++++++++++
 1 files changed

// File: rtl/snn_layer_par.sv
// snn_layer_par: layer of leaky integrate-and-fire neurons fed by serially accumulated synaptic inputs
module snn_layer_par #(
    parameter int DW = 16,
    parameter int INT_DW = 8,
    parameter int INPUTNUM = 4,
    parameter int EXCNUM = 2,
    parameter int THRESH = 1000,
    parameter int LEAK_SHIFT = 4,
    parameter int REFRAC = 2,
    parameter int WTA = 0,
    localparam int MW = DW + INT_DW,
    localparam int NW = INPUTNUM * EXCNUM,
    localparam int AW = NW > 1 ? $clog2(NW) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [DW-1:0]       wr_data,
    output logic                wr_drop,
    input  logic                step_valid,
    input  logic [INPUTNUM-1:0] pre_spike,
    output logic                step_ready,
    output logic                out_valid,
    output logic [EXCNUM-1:0]   out_spike
);
    localparam int IW = INPUTNUM > 1 ? $clog2(INPUTNUM) : 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] FIRE = 2'd2;
    localparam logic signed [MW+1:0] VMAX = {3'b000, {(MW-1){1'b1}}};
    localparam logic signed [MW+1:0] VMIN = {3'b111, {(MW-1){1'b0}}};
    localparam logic signed [MW-1:0] TH = MW'(THRESH);

    logic [1:0] state;
    logic [IW-1:0] idx;
    logic [INPUTNUM-1:0] pre_q;
    logic signed [DW-1:0] w_q [NW];
    logic signed [MW-1:0] acc_q [EXCNUM];
    logic signed [MW-1:0] v_q [EXCNUM];
    logic [3:0] rc_q [EXCNUM];
    logic signed [MW-1:0] v_sat [EXCNUM];
    logic [EXCNUM-1:0] raw, win;
    logic multi, inhibit, wr_ok;

    assign step_ready = state == IDLE && en;
    assign wr_ok = wr_en && state == IDLE && int'(wr_addr) < NW;

    // candidate membrane update: leak, integrate, saturate, threshold test
    for (genvar j = 0; j < EXCNUM; j++) begin : g_n
        logic signed [MW+1:0] vx, lk, vn;
        assign vx = (MW+2)'(v_q[j]);
        assign lk = LEAK_SHIFT == 0 ? (MW+2)'(0) : vx >>> LEAK_SHIFT;
        assign vn = vx - lk + (MW+2)'(acc_q[j]);
        assign v_sat[j] = vn > VMAX ? VMAX[MW-1:0] : vn < VMIN ? VMIN[MW-1:0] : vn[MW-1:0];
        assign raw[j] = rc_q[j] == 4'd0 && v_sat[j] >= TH;
    end

    // lateral inhibition keeps only the lowest-index spiker when several fire
    assign multi = (raw & (raw - EXCNUM'(1))) != '0;
    assign inhibit = WTA != 0 && multi;
    assign win = inhibit ? raw & (~raw + EXCNUM'(1)) : raw;

    // control FSM, weight memory and neuron state
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            idx <= '0;
            pre_q <= '0;
            out_spike <= '0;
            out_valid <= 1'b0;
            wr_drop <= 1'b0;
            for (int k = 0; k < NW; k++) w_q[k] <= '0;
            for (int j = 0; j < EXCNUM; j++) begin
                acc_q[j] <= '0;
                v_q[j] <= '0;
                rc_q[j] <= '0;
            end
        end else begin
            out_valid <= 1'b0;
            wr_drop <= wr_en && !wr_ok;
            if (wr_ok) w_q[wr_addr] <= wr_data;
            if (en) begin
                if (state == IDLE && step_valid) begin
                    state <= ACCUM;
                    idx <= '0;
                    pre_q <= pre_spike;
                    for (int j = 0; j < EXCNUM; j++) acc_q[j] <= '0;
                end else if (state == ACCUM) begin
                    for (int j = 0; j < EXCNUM; j++)
                        if (pre_q[idx]) acc_q[j] <= acc_q[j] + MW'(w_q[int'(idx) * EXCNUM + j]);
                    idx <= idx + IW'(1);
                    if (int'(idx) == INPUTNUM - 1) state <= FIRE;
                end else if (state == FIRE) begin
                    state <= IDLE;
                    out_valid <= 1'b1;
                    out_spike <= win;
                    for (int j = 0; j < EXCNUM; j++) begin
                        if (rc_q[j] != 4'd0) begin
                            v_q[j] <= '0;
                            rc_q[j] <= rc_q[j] - 4'd1;
                        end else if (win[j]) begin
                            v_q[j] <= '0;
                            rc_q[j] <= 4'(REFRAC);
                        end else begin
                            v_q[j] <= inhibit ? '0 : v_sat[j];
                        end
                    end
                end
            end
        end
    end
endmodule
